// File: rtl/ahb_apb_fsm_pkg.sv
// Shared definitions for the AHB-to-APB bridge controller: state encoding,
// AHB transfer/response codes and default bus geometry.
package ahb_apb_fsm_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SLAVES_DEF  = 4;
  localparam int SEL_LSB_DEF = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/ahb_apb_addr_decode.sv
// Combinational slave decode: a field of the AHB address selects one of
// SLAVES APB peripherals, presented as a one-hot select vector.
module ahb_apb_addr_decode #(
  parameter int WIDTH   = 32,
  parameter int SLAVES  = 4,
  parameter int SEL_LSB = 28
) (
  input  logic [WIDTH-1:0]  addr,
  output logic [SLAVES-1:0] sel
);

  localparam int IW = $clog2(SLAVES);

  logic [IW-1:0] idx;
  logic          unused_addr;

  assign idx = addr[SEL_LSB +: IW];

  // Bits outside the select field play no part in the decode.
  assign unused_addr = ^addr;

  genvar gi;
  generate
    for (gi = 0; gi < SLAVES; gi++) begin : g_sel
      assign sel[gi] = (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/ahb_apb_fsm.sv
// AHB-to-APB bridge controller: samples AHB address/data phases, sequences
// APB SETUP/ACCESS for zero-wait slaves and stretches the AHB data phase.
module ahb_apb_fsm
  import ahb_apb_fsm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLAVES  = SLAVES_DEF,
  parameter int SEL_LSB = SEL_LSB_DEF
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hsel,
  input  logic [WIDTH-1:0]  Haddr,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [WIDTH-1:0]  Hwdata,
  input  logic              Hreadyin,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [WIDTH-1:0]  Hrdata,
  output logic [WIDTH-1:0]  Paddr_in,
  output logic              Pwrite_in,
  output logic              Penable_in,
  output logic [WIDTH-1:0]  Pwdata_in,
  output logic [SLAVES-1:0] Pselx_in,
  input  logic [WIDTH-1:0]  Prdata_in
);

  state_e            state_reg, state_next;
  logic [WIDTH-1:0]  addr_q_reg, addr_q_next;
  logic              write_q_reg, write_q_next;
  logic [WIDTH-1:0]  paddr_reg, paddr_next;
  logic [WIDTH-1:0]  pwdata_reg, pwdata_next;
  logic              pwrite_reg, pwrite_next;
  logic              penable_reg, penable_next;
  logic [SLAVES-1:0] psel_reg, psel_next;

  logic [SLAVES-1:0] sel_haddr;
  logic [SLAVES-1:0] sel_addr_q;
  logic              valid;

  ahb_apb_addr_decode #(.WIDTH(WIDTH), .SLAVES(SLAVES), .SEL_LSB(SEL_LSB)) u_dec_haddr (
    .addr (Haddr),
    .sel  (sel_haddr)
  );

  ahb_apb_addr_decode #(.WIDTH(WIDTH), .SLAVES(SLAVES), .SEL_LSB(SEL_LSB)) u_dec_addr_q (
    .addr (addr_q_reg),
    .sel  (sel_addr_q)
  );

  assign valid = Hsel & Hreadyin & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_reg   <= ST_IDLE;
      addr_q_reg  <= '0;
      write_q_reg <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pwrite_reg  <= 1'b0;
      penable_reg <= 1'b0;
      psel_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      addr_q_reg  <= addr_q_next;
      write_q_reg <= write_q_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      pwrite_reg  <= pwrite_next;
      penable_reg <= penable_next;
      psel_reg    <= psel_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_q_next  = addr_q_reg;
    write_q_next = write_q_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    pwrite_next  = pwrite_reg;
    penable_next = penable_reg;
    psel_next    = psel_reg;
    case (state_reg)
      ST_IDLE, ST_ACCESS: begin
        psel_next    = '0;
        penable_next = 1'b0;
        if (!valid) begin
          state_next = ST_IDLE;
        end else if (Hwrite) begin
          // Writes wait one cycle for Hwdata before the APB SETUP phase.
          state_next   = ST_WWAIT;
          addr_q_next  = Haddr;
          write_q_next = 1'b1;
        end else begin
          state_next   = ST_SETUP;
          write_q_next = 1'b0;
          paddr_next   = Haddr;
          pwrite_next  = 1'b0;
          psel_next    = sel_haddr;
        end
      end
      ST_WWAIT: begin
        state_next   = ST_SETUP;
        pwdata_next  = Hwdata;
        paddr_next   = addr_q_reg;
        pwrite_next  = write_q_reg;
        psel_next    = sel_addr_q;
        penable_next = 1'b0;
      end
      ST_SETUP: begin
        state_next   = ST_ACCESS;
        penable_next = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign Hreadyout  = (state_reg == ST_IDLE) || (state_reg == ST_ACCESS);
  assign Hresp      = HRESP_OKAY;
  assign Hrdata     = Prdata_in;
  assign Paddr_in   = paddr_reg;
  assign Pwdata_in  = pwdata_reg;
  assign Pwrite_in  = pwrite_reg;
  assign Penable_in = penable_reg;
  assign Pselx_in   = psel_reg;

endmodule

// File: tb/tb_ahb_apb_fsm.sv
// Directed bench for the AHB-to-APB bridge controller; inputs change and
// outputs are sampled on the falling clock edge.
module tb_ahb_apb_fsm;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hsel;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr_in;
  logic        Pwrite_in;
  logic        Penable_in;
  logic [31:0] Pwdata_in;
  logic [3:0]  Pselx_in;
  logic [31:0] Prdata_in;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Hclk = ~Hclk;

  ahb_apb_fsm dut (
    .Hclk       (Hclk),
    .Hresetn    (Hresetn),
    .Hsel       (Hsel),
    .Haddr      (Haddr),
    .Htrans     (Htrans),
    .Hwrite     (Hwrite),
    .Hwdata     (Hwdata),
    .Hreadyin   (Hreadyin),
    .Hreadyout  (Hreadyout),
    .Hresp      (Hresp),
    .Hrdata     (Hrdata),
    .Paddr_in   (Paddr_in),
    .Pwrite_in  (Pwrite_in),
    .Penable_in (Penable_in),
    .Pwdata_in  (Pwdata_in),
    .Pselx_in   (Pselx_in),
    .Prdata_in  (Prdata_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Hclk);
  endtask

  task automatic drive_idle();
    Hsel   = 1'b0;
    Htrans = 2'b00;
    Hwrite = 1'b0;
  endtask

  task automatic drive_xfer(input logic [31:0] addr, input logic wr);
    Hsel   = 1'b1;
    Htrans = 2'b10;
    Haddr  = addr;
    Hwrite = wr;
  endtask

  initial begin
    Hresetn   = 1'b0;
    Hreadyin  = 1'b1;
    Haddr     = '0;
    Hwdata    = '0;
    Prdata_in = 32'hDEAD_BEEF;
    drive_idle();
    tick();
    tick();
    check("rst_hreadyout", {31'd0, Hreadyout}, 32'd1);
    check("rst_psel", {28'd0, Pselx_in}, 32'd0);
    check("rst_paddr", Paddr_in, 32'd0);
    Hresetn = 1'b1;

    // Idle with Hsel low
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_hreadyout", {31'd0, Hreadyout}, 32'd1);
      check("idle_psel", {28'd0, Pselx_in}, 32'd0);
      check("idle_penable", {31'd0, Penable_in}, 32'd0);
    end
    check("idle_hresp", {30'd0, Hresp}, 32'd0);
    $display("[TB] idle cycles done");

    // Single read
    drive_xfer(32'h2000_0010, 1'b0);
    tick();
    drive_idle();
    check("rd_setup_psel", {28'd0, Pselx_in}, 32'h4);
    check("rd_setup_paddr", Paddr_in, 32'h2000_0010);
    check("rd_setup_penable", {31'd0, Penable_in}, 32'd0);
    check("rd_setup_hready", {31'd0, Hreadyout}, 32'd0);
    check("rd_setup_pwrite", {31'd0, Pwrite_in}, 32'd0);
    tick();
    check("rd_access_penable", {31'd0, Penable_in}, 32'd1);
    check("rd_access_hready", {31'd0, Hreadyout}, 32'd1);
    check("rd_access_hrdata", Hrdata, 32'hDEAD_BEEF);
    tick();
    check("rd_after_psel", {28'd0, Pselx_in}, 32'd0);
    check("rd_after_penable", {31'd0, Penable_in}, 32'd0);
    check("rd_after_paddr_hold", Paddr_in, 32'h2000_0010);
    $display("[TB] read 0x20000010 -> 0x%08h", Hrdata);

    // Single write; Haddr changes during the data phase must be ignored
    drive_xfer(32'h1000_0004, 1'b1);
    tick();
    drive_idle();
    Haddr  = 32'h3000_0000;
    Hwdata = 32'h1234_5678;
    check("wr_wwait_hready", {31'd0, Hreadyout}, 32'd0);
    check("wr_wwait_psel", {28'd0, Pselx_in}, 32'd0);
    tick();
    Hwdata = 32'hFFFF_FFFF;
    check("wr_setup_psel", {28'd0, Pselx_in}, 32'h2);
    check("wr_setup_pwrite", {31'd0, Pwrite_in}, 32'd1);
    check("wr_setup_pwdata", Pwdata_in, 32'h1234_5678);
    check("wr_setup_paddr", Paddr_in, 32'h1000_0004);
    check("wr_setup_penable", {31'd0, Penable_in}, 32'd0);
    check("wr_setup_hready", {31'd0, Hreadyout}, 32'd0);
    tick();
    check("wr_access_penable", {31'd0, Penable_in}, 32'd1);
    check("wr_access_hready", {31'd0, Hreadyout}, 32'd1);
    check("wr_access_pwdata", Pwdata_in, 32'h1234_5678);
    tick();
    check("wr_after_psel", {28'd0, Pselx_in}, 32'd0);
    $display("[TB] write 0x10000004 <- 0x12345678");

    // Back-to-back reads, second accepted in ACCESS
    drive_xfer(32'h0000_0000, 1'b0);
    tick();
    drive_idle();
    check("b2b_s1_psel", {28'd0, Pselx_in}, 32'h1);
    check("b2b_s1_penable", {31'd0, Penable_in}, 32'd0);
    tick();
    check("b2b_a1_psel", {28'd0, Pselx_in}, 32'h1);
    check("b2b_a1_penable", {31'd0, Penable_in}, 32'd1);
    drive_xfer(32'h3000_0000, 1'b0);
    tick();
    drive_idle();
    check("b2b_s2_psel", {28'd0, Pselx_in}, 32'h8);
    check("b2b_s2_penable", {31'd0, Penable_in}, 32'd0);
    check("b2b_s2_paddr", Paddr_in, 32'h3000_0000);
    check("b2b_s2_hready", {31'd0, Hreadyout}, 32'd0);
    tick();
    check("b2b_a2_psel", {28'd0, Pselx_in}, 32'h8);
    check("b2b_a2_penable", {31'd0, Penable_in}, 32'd1);
    tick();
    $display("[TB] read-read 0x00000000, 0x30000000");

    // Write followed by read accepted in the write's ACCESS cycle
    drive_xfer(32'h1000_0008, 1'b1);
    tick();
    drive_idle();
    Hwdata = 32'hA5A5_0001;
    check("wr_rd_c1_hready", {31'd0, Hreadyout}, 32'd0);
    tick();
    check("wr_rd_c2_hready", {31'd0, Hreadyout}, 32'd0);
    check("wr_rd_c2_pwdata", Pwdata_in, 32'hA5A5_0001);
    tick();
    check("wr_rd_c3_hready", {31'd0, Hreadyout}, 32'd1);
    check("wr_rd_c3_pwrite", {31'd0, Pwrite_in}, 32'd1);
    drive_xfer(32'h2000_0020, 1'b0);
    tick();
    drive_idle();
    check("wr_rd_c4_hready", {31'd0, Hreadyout}, 32'd0);
    check("wr_rd_c4_pwrite", {31'd0, Pwrite_in}, 32'd0);
    check("wr_rd_c4_psel", {28'd0, Pselx_in}, 32'h4);
    check("wr_rd_c4_paddr", Paddr_in, 32'h2000_0020);
    tick();
    check("wr_rd_c5_hready", {31'd0, Hreadyout}, 32'd1);
    check("wr_rd_c5_penable", {31'd0, Penable_in}, 32'd1);
    tick();
    $display("[TB] write-read 0x10000008, 0x20000020");

    // Asynchronous reset during the SETUP phase of a write
    drive_xfer(32'h1000_000C, 1'b1);
    tick();
    drive_idle();
    Hwdata = 32'h5555_AAAA;
    tick();
    check("rst_mid_pre_psel", {28'd0, Pselx_in}, 32'h2);
    #1 Hresetn = 1'b0;
    #1;
    check("rst_mid_psel", {28'd0, Pselx_in}, 32'd0);
    check("rst_mid_pwrite", {31'd0, Pwrite_in}, 32'd0);
    check("rst_mid_pwdata", Pwdata_in, 32'd0);
    check("rst_mid_paddr", Paddr_in, 32'd0);
    check("rst_mid_penable", {31'd0, Penable_in}, 32'd0);
    check("rst_mid_hready", {31'd0, Hreadyout}, 32'd1);
    tick();
    Hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_post_psel", {28'd0, Pselx_in}, 32'd0);
      check("rst_post_penable", {31'd0, Penable_in}, 32'd0);
      check("rst_post_hready", {31'd0, Hreadyout}, 32'd1);
    end
    $display("[TB] reset during write setup");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
